// File: rtl/axi_slave_arbiter.sv
// Two-master arbiter in front of a single-transaction AXI register slave.
// One grant covers a whole burst; round-robin between masters, read before write.
module axi_slave_arbiter #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              res,
    // master 0
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [3:0]        m0_arlen,
    input  logic [2:0]        m0_arsize,
    input  logic [1:0]        m0_arburst,
    output logic              m0_arready,
    input  logic              m0_awvalid,
    input  logic [ADDR_W-1:0] m0_awaddr,
    input  logic [3:0]        m0_awlen,
    input  logic [2:0]        m0_awsize,
    input  logic [1:0]        m0_awburst,
    output logic              m0_awready,
    input  logic              m0_wvalid,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_wlast,
    output logic              m0_wready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    output logic              m0_rlast,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic              m0_bvalid,
    output logic [1:0]        m0_bresp,
    input  logic              m0_bready,
    // master 1
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [3:0]        m1_arlen,
    input  logic [2:0]        m1_arsize,
    input  logic [1:0]        m1_arburst,
    output logic              m1_arready,
    input  logic              m1_awvalid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic [3:0]        m1_awlen,
    input  logic [2:0]        m1_awsize,
    input  logic [1:0]        m1_awburst,
    output logic              m1_awready,
    input  logic              m1_wvalid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_wlast,
    output logic              m1_wready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              m1_rlast,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic              m1_bvalid,
    output logic [1:0]        m1_bresp,
    input  logic              m1_bready,
    // slave port
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [3:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    input  logic              s_arready,
    output logic              s_awvalid,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic [3:0]        s_awlen,
    output logic [2:0]        s_awsize,
    output logic [1:0]        s_awburst,
    input  logic              s_awready,
    output logic              s_wvalid,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_wlast,
    input  logic              s_wready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    output logic              s_bready,
    // status
    output logic              owner,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        win;
    logic        slv_hs;

    // Request channels of the current owner
    logic              sel_arvalid, sel_awvalid, sel_wvalid, sel_wlast, sel_rready, sel_bready;
    logic [ADDR_W-1:0] sel_araddr, sel_awaddr;
    logic [3:0]        sel_arlen, sel_awlen;
    logic [2:0]        sel_arsize, sel_awsize;
    logic [1:0]        sel_arburst, sel_awburst;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        if (owner_q) begin
            sel_arvalid = m1_arvalid;  sel_araddr  = m1_araddr;  sel_arlen = m1_arlen;
            sel_arsize  = m1_arsize;   sel_arburst = m1_arburst;
            sel_awvalid = m1_awvalid;  sel_awaddr  = m1_awaddr;  sel_awlen = m1_awlen;
            sel_awsize  = m1_awsize;   sel_awburst = m1_awburst;
            sel_wvalid  = m1_wvalid;   sel_wdata   = m1_wdata;   sel_wlast = m1_wlast;
            sel_rready  = m1_rready;   sel_bready  = m1_bready;
        end else begin
            sel_arvalid = m0_arvalid;  sel_araddr  = m0_araddr;  sel_arlen = m0_arlen;
            sel_arsize  = m0_arsize;   sel_arburst = m0_arburst;
            sel_awvalid = m0_awvalid;  sel_awaddr  = m0_awaddr;  sel_awlen = m0_awlen;
            sel_awsize  = m0_awsize;   sel_awburst = m0_awburst;
            sel_wvalid  = m0_wvalid;   sel_wdata   = m0_wdata;   sel_wlast = m0_wlast;
            sel_rready  = m0_rready;   sel_bready  = m0_bready;
        end
    end

    // Slave-facing requests
    always_comb begin
        s_arvalid = 1'b0;  s_araddr = '0;  s_arlen = '0;  s_arsize = '0;  s_arburst = '0;
        s_awvalid = 1'b0;  s_awaddr = '0;  s_awlen = '0;  s_awsize = '0;  s_awburst = '0;
        s_wvalid  = 1'b0;  s_wdata  = '0;  s_wlast = 1'b0;
        s_rready  = 1'b0;  s_bready = 1'b0;
        if (state_q == StRd) begin
            s_arvalid = sel_arvalid;  s_araddr  = sel_araddr;  s_arlen = sel_arlen;
            s_arsize  = sel_arsize;   s_arburst = sel_arburst; s_rready = sel_rready;
        end
        if (state_q == StWr) begin
            s_awvalid = sel_awvalid;  s_awaddr  = sel_awaddr;  s_awlen = sel_awlen;
            s_awsize  = sel_awsize;   s_awburst = sel_awburst;
            s_wvalid  = sel_wvalid;   s_wdata   = sel_wdata;   s_wlast = sel_wlast;
            s_bready  = sel_bready;
        end
    end

    // Master-facing responses; the non-owner sees all zeros
    always_comb begin
        m0_arready = 1'b0;  m0_awready = 1'b0;  m0_wready = 1'b0;
        m0_rdata   = '0;    m0_rresp   = '0;    m0_rlast  = 1'b0;  m0_rvalid = 1'b0;
        m0_bvalid  = 1'b0;  m0_bresp   = '0;
        m1_arready = 1'b0;  m1_awready = 1'b0;  m1_wready = 1'b0;
        m1_rdata   = '0;    m1_rresp   = '0;    m1_rlast  = 1'b0;  m1_rvalid = 1'b0;
        m1_bvalid  = 1'b0;  m1_bresp   = '0;
        if (state_q == StRd) begin
            if (owner_q) begin
                m1_arready = s_arready;  m1_rdata = s_rdata;  m1_rresp = s_rresp;
                m1_rlast   = s_rlast;    m1_rvalid = s_rvalid;
            end else begin
                m0_arready = s_arready;  m0_rdata = s_rdata;  m0_rresp = s_rresp;
                m0_rlast   = s_rlast;    m0_rvalid = s_rvalid;
            end
        end
        if (state_q == StWr) begin
            if (owner_q) begin
                m1_awready = s_awready;  m1_wready = s_wready;
                m1_bvalid  = s_bvalid;   m1_bresp  = s_bresp;
            end else begin
                m0_awready = s_awready;  m0_wready = s_wready;
                m0_bvalid  = s_bvalid;   m0_bresp  = s_bresp;
            end
        end
    end

    // Grant and burst tracking
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        win     = owner_q;
        unique case (state_q)
            StIdle: begin
                if ((m0_arvalid | m0_awvalid) | (m1_arvalid | m1_awvalid)) begin
                    if ((m0_arvalid | m0_awvalid) && (m1_arvalid | m1_awvalid)) begin
                        win = ~owner_q;
                    end else begin
                        win = m1_arvalid | m1_awvalid;
                    end
                    owner_d = win;
                    state_d = (win ? m1_arvalid : m0_arvalid) ? StRd : StWr;
                end
            end
            StRd: if (s_rvalid && s_rlast && s_rready) state_d = StIdle;
            StWr: if (s_bvalid && s_bready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Any slave handshake counts as progress
    assign slv_hs = (s_arvalid & s_arready) | (s_awvalid & s_awready) | (s_wvalid & s_wready) |
                    (s_rvalid & s_rready) | (s_bvalid & s_bready);

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == StIdle || slv_hs) begin
            cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (state_q != StIdle && cnt_q == 8'(TIMEOUT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= StIdle;
            owner_q <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign owner       = owner_q;
    assign busy        = (state_q != StIdle);
    assign err_timeout = err_q;

endmodule
